// File: rtl/regfile_dumper_pkg.sv
// Shared types and defaults for the register-file dumper.
// Optional checksum beat is enabled with REGFILE_DUMPER_CHECKSUM_EN.
package regfile_dumper_pkg;

  localparam int DEFAULT_NUM_REGS   = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_SEL_WIDTH  = $clog2(DEFAULT_NUM_REGS);
  localparam int STATE_WIDTH        = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_STREAM  = 3'd2,
`ifdef REGFILE_DUMPER_CHECKSUM_EN
    ST_CKSUM   = 3'd3,
`endif
    ST_DONE    = 3'd4
  } state_t;

  // Index width that stays legal for a single-register configuration.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regdump_snapshot.sv
// Snapshot buffer holding one coherent copy of the register file.
// Provides an XOR reduction of all bytes when REGFILE_DUMPER_CHECKSUM_EN is defined.
module regdump_snapshot
  import regfile_dumper_pkg::*;
#(
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IDX_W      = sel_width(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
`ifdef REGFILE_DUMPER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] xor_all
`endif
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

`ifdef REGFILE_DUMPER_CHECKSUM_EN
  always_comb begin
    xor_all = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      xor_all = xor_all ^ mem[i];
    end
  end
`endif

endmodule

// File: rtl/regfile_dumper.sv
// Snapshots the register file through one read port, then streams it out over valid/ready.
// REGFILE_DUMPER_CHECKSUM_EN appends an XOR checksum beat after the register bytes.
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int IDX_W     = sel_width(NUM_REGS)
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   start,
  output logic [IDX_W-1:0]       reg_sel,
  input  logic [DATA_WIDTH-1:0]  reg_data,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic [STATE_WIDTH-1:0] dbg_state
);

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // out_valid/out_data are registered and hold until that transfer (or reset).

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t                state, state_n;
  logic [IDX_W-1:0]      index, index_n;
  logic [DATA_WIDTH-1:0] out_data_n;
  logic                  out_valid_n, busy_n, done_n;
  logic                  snap_we;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_data, first_beat;
  logic                  last, hs;
`ifdef REGFILE_DUMPER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] xor_all;
`endif

  regdump_snapshot #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_snapshot (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .we      (snap_we),
    .wr_idx  (index),
    .wr_data (reg_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
`ifdef REGFILE_DUMPER_CHECKSUM_EN
    ,
    .xor_all (xor_all)
`endif
  );

  assign reg_sel   = index;
  assign dbg_state = state;
  assign last      = (index == LAST_IDX);
  assign hs        = out_valid && out_ready;

  // With one register the first beat is being captured on the same edge it is presented.
  assign first_beat = (NUM_REGS == 1) ? reg_data : rd_data;

  always_comb begin
    state_n     = state;
    index_n     = index;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    done_n      = 1'b0;
    snap_we     = 1'b0;
    rd_idx      = '0;
    if (state == ST_STREAM && !last) begin
      rd_idx = index + 1'b1;
    end
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_CAPTURE;
          index_n = '0;
        end
      end
      ST_CAPTURE: begin
        snap_we = 1'b1;
        if (last) begin
          state_n     = ST_STREAM;
          index_n     = '0;
          out_valid_n = 1'b1;
          out_data_n  = first_beat;
        end else begin
          index_n = index + 1'b1;
        end
      end
      ST_STREAM: begin
        if (hs) begin
          if (last) begin
`ifdef REGFILE_DUMPER_CHECKSUM_EN
            state_n    = ST_CKSUM;
            out_data_n = xor_all;
`else
            state_n     = ST_DONE;
            index_n     = '0;
            out_valid_n = 1'b0;
            done_n      = 1'b1;
`endif
          end else begin
            index_n    = index + 1'b1;
            out_data_n = rd_data;
          end
        end
      end
`ifdef REGFILE_DUMPER_CHECKSUM_EN
      ST_CKSUM: begin
        if (hs) begin
          state_n     = ST_DONE;
          index_n     = '0;
          out_valid_n = 1'b0;
          done_n      = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n     = ST_IDLE;
        index_n     = '0;
        out_valid_n = 1'b0;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      index     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      index     <= index_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule
